spram_arbiter: RTL and testbench

- Shares one single-port RAM (1-cycle registered read; on write, q returns the written data) between a video scanout requester and a CPU requester.
- Video has fixed priority. A starvation guard reserves slots for the CPU.
- An optional power-on clear sequencer fills the RAM before any requester is served.
- Sits between the CPU bus and the video fetch logic and the spram instance in the game core.

---
 rtl/spram_arbiter_if.sv | 31 +++
 rtl/spram_arbiter.sv | 123 ++++++++++++
 tb/tb_spram_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spram_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (video, CPU) and the spram.
// slave = arbiter side, master = requester/RAM side.
interface spram_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_dout;
    logic              vid_valid;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_q,
        output vid_dout, vid_valid, cpu_dout, cpu_ack, ram_address, ram_data, ram_wren
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, ram_q,
        input  vid_dout, vid_valid, cpu_dout, cpu_ack, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between video scanout (fixed priority) and the CPU.
// Define SPRAM_ARB_CLEAR_EN to fill the RAM with CLEAR_VALUE after every reset.
module spram_arbiter #(
    parameter int unsigned       ADDR_W       = 10,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic           clk,
    input  logic           reset_n,
    spram_arbiter_if.slave bus,
    output logic           clear_busy
);
    localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {S_CLEAR, S_RUN} state_t;
`ifdef SPRAM_ARB_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_RUN;
`endif

    state_t           state, state_nx;
    logic             vid_pend, cpu_pend;
    logic             vid_elig, cpu_elig, vid_win, cpu_win;
    logic [CNT_W-1:0] starve;
    logic             s1_valid, s1_cpu, s2_valid, s2_cpu;

`ifdef SPRAM_ARB_CLEAR_EN
    // Extra MSB marks the idle edge after the last address, where RUN begins.
    logic [ADDR_W:0] clr_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
        end else if (state == S_CLEAR) begin
            if (clr_cnt[ADDR_W]) clear_busy <= 1'b0;
            else                 clr_cnt    <= clr_cnt + (ADDR_W + 1)'(1);
        end
    end
`else
    assign clear_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
`ifdef SPRAM_ARB_CLEAR_EN
        if (state == S_CLEAR && clr_cnt[ADDR_W]) state_nx = S_RUN;
`endif
        vid_elig = (state == S_RUN) && bus.vid_req && !vid_pend;
        cpu_elig = (state == S_RUN) && bus.cpu_req && !cpu_pend;
        cpu_win  = cpu_elig && (!vid_elig || starve == LIMIT);
        vid_win  = vid_elig && !cpu_win;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_address <= '0;
            bus.ram_data    <= '0;
            bus.ram_wren    <= 1'b0;
            bus.vid_dout    <= '0;
            bus.vid_valid   <= 1'b0;
            bus.cpu_dout    <= '0;
            bus.cpu_ack     <= 1'b0;
            vid_pend        <= 1'b0;
            cpu_pend        <= 1'b0;
            starve          <= '0;
            s1_valid        <= 1'b0;
            s1_cpu          <= 1'b0;
            s2_valid        <= 1'b0;
            s2_cpu          <= 1'b0;
        end else begin
            // Source tag travels alongside the RAM's one-cycle read latency.
            s1_valid      <= vid_win || cpu_win;
            s1_cpu        <= cpu_win;
            s2_valid      <= s1_valid;
            s2_cpu        <= s1_cpu;
            bus.vid_valid <= s2_valid && !s2_cpu;
            bus.cpu_ack   <= s2_valid && s2_cpu;

            if (s2_valid && !s2_cpu) begin
                bus.vid_dout <= bus.ram_q;
                vid_pend     <= 1'b0;
            end
            if (s2_valid && s2_cpu) begin
                bus.cpu_dout <= bus.ram_q;
                cpu_pend     <= 1'b0;
            end
            if (vid_win) vid_pend <= 1'b1;
            if (cpu_win) cpu_pend <= 1'b1;

            if (cpu_win || !cpu_elig)             starve <= '0;
            else if (vid_win && starve != LIMIT)  starve <= starve + CNT_W'(1);

`ifdef SPRAM_ARB_CLEAR_EN
            if (state == S_CLEAR) begin
                bus.ram_wren <= !clr_cnt[ADDR_W];
                if (!clr_cnt[ADDR_W]) begin
                    bus.ram_address <= clr_cnt[ADDR_W-1:0];
                    bus.ram_data    <= CLEAR_VALUE;
                end
            end else
`endif
            if (cpu_win) begin
                bus.ram_address <= bus.cpu_addr;
                bus.ram_data    <= bus.cpu_din;
                bus.ram_wren    <= bus.cpu_we;
            end else if (vid_win) begin
                bus.ram_address <= bus.vid_addr;
                bus.ram_wren    <= 1'b0;
            end else begin
                bus.ram_wren    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural RAM, issue-time model and directed vectors.
// Build with SPRAM_ARB_CLEAR_EN defined to exercise the clear sequencer (ADDR_W = 4).
module tb_spram_arbiter;
`ifdef SPRAM_ARB_CLEAR_EN
    localparam int AW  = 4;
    localparam bit CLR = 1'b1;
`else
    localparam int AW  = 10;
    localparam bit CLR = 1'b0;
`endif
    localparam int        DW    = 8;
    localparam int        LIMIT = 4;
    localparam logic [7:0] CV   = 8'h00;
    localparam logic [7:0] INIT = 8'hEE;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_busy;
    int   n_vec = 0;
    int   n_fail = 0;

    spram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT), .CLEAR_VALUE(CV)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    // External spram: registered read, write-through on q.
    logic [DW-1:0] ram [2**AW];
    initial for (int i = 0; i < 2**AW; i++) ram[i] = INIT;
    always @(posedge clk) begin
        if (bus.ram_wren) begin
            ram[bus.ram_address] = bus.ram_data;
            bus.ram_q <= bus.ram_data;
        end else begin
            bus.ram_q <= ram[bus.ram_address];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each op completes exactly two edges after the edge that grants it,
    // with the data the memory holds at grant time.
    logic [DW-1:0] mmem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) mmem[i] = INIT;
    int            cyc, m_vi, m_ci, m_starve, m_clr_left;
    bit            m_vp, m_cp, exp_vv, exp_ca, exp_busy, exp_clr_w;
    logic [DW-1:0] m_vd, m_cd, exp_vdout, exp_cdout;
    logic [AW-1:0] exp_clr_a;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; m_vp = 0; m_cp = 0; m_starve = 0;
            exp_vv = 0; exp_ca = 0; exp_vdout = '0; exp_cdout = '0;
            exp_busy = CLR; exp_clr_w = 0;
            m_clr_left = CLR ? 2**AW + 1 : 0;
            if (CLR) for (int i = 0; i < 2**AW; i++) mmem[i] = CV;
        end else begin
            bit ve, ce, vw, cw;
            cyc++;
            exp_vv = 0; exp_ca = 0; exp_clr_w = 0;
            if (m_clr_left > 0) begin
                if (m_clr_left > 1) begin
                    exp_clr_w = 1;
                    exp_clr_a = AW'(2**AW + 1 - m_clr_left);
                end
                m_clr_left--;
                if (m_clr_left == 0) exp_busy = 0;
            end else begin
                ve = bus.vid_req && !m_vp;
                ce = bus.cpu_req && !m_cp;
                if (m_vp && cyc == m_vi + 2) begin exp_vv = 1; exp_vdout = m_vd; m_vp = 0; end
                if (m_cp && cyc == m_ci + 2) begin exp_ca = 1; exp_cdout = m_cd; m_cp = 0; end
                cw = ce && (!ve || m_starve == LIMIT);
                vw = ve && !cw;
                if (cw) begin
                    m_cp = 1; m_ci = cyc;
                    if (bus.cpu_we) begin mmem[bus.cpu_addr] = bus.cpu_din; m_cd = bus.cpu_din; end
                    else m_cd = mmem[bus.cpu_addr];
                end
                if (vw) begin m_vp = 1; m_vi = cyc; m_vd = mmem[bus.vid_addr]; end
                if (cw || !ce)                 m_starve = 0;
                else if (vw && m_starve < LIMIT) m_starve++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("vid_valid", bus.vid_valid, exp_vv);
            check("cpu_ack", bus.cpu_ack, exp_ca);
            check("vid_dout", bus.vid_dout, exp_vdout);
            check("cpu_dout", bus.cpu_dout, exp_cdout);
            check("clear_busy", clear_busy, exp_busy);
            if (exp_clr_w) begin
                check("clr_wren", bus.ram_wren, 1);
                check("clr_addr", bus.ram_address, exp_clr_a);
                check("clr_data", bus.ram_data, CV);
            end
        end
    end

    // Returns the number of negedges from raising req to seeing the ack.
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] q);
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_din = d;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.cpu_ack) break;
            bus.cpu_addr = ~a; bus.cpu_din = ~d;
        end
        if (!bus.cpu_ack) check("cpu_timeout", 0, 1);
        q = bus.cpu_dout;
        bus.cpu_req = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            lat, vl, cl, nv, nc;
        logic [DW-1:0] q;
        logic [9:0]    a10;
        logic [9:0]    tv_a [4] = '{10'h000, 10'h3FF, 10'h0AA, 10'h155};
        logic [7:0]    tv_d [4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};

        bus.vid_req = 0; bus.vid_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
        bus.cpu_addr = '0; bus.cpu_din = '0;
        #12;
        check("rst_clear_busy", clear_busy, CLR);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_addr", bus.ram_address, 0);
        check("rst_vid_valid", bus.vid_valid, 0);
        check("rst_cpu_ack", bus.cpu_ack, 0);
        @(posedge clk); #2 reset_n = 1;

        // First request straight out of reset (held across the clear when enabled).
        cpu_op(0, AW'(5), '0, lat, q);
        check("first_lat", lat, CLR ? 2**AW + 4 : 3);
        check("first_data", q, CLR ? CV : INIT);
        check("first_busy", clear_busy, 0);

        a10 = 10'h123;
        cpu_op(1, a10[AW-1:0], 8'h5A, lat, q);
        check("wr_lat", lat, 3);
        check("wr_dout", q, 8'h5A);
        cpu_op(0, a10[AW-1:0], 8'h00, lat, q);
        check("rd_lat", lat, 3);
        check("rd_dout", q, 8'h5A);

        for (int i = 0; i < 4; i++) begin
            a10 = tv_a[i];
            cpu_op(1, a10[AW-1:0], tv_d[i], lat, q);
        end
        for (int i = 0; i < 4; i++) begin
            a10 = tv_a[i];
            cpu_op(0, a10[AW-1:0], 8'h00, lat, q);
            check("tbl_rd", q, tv_d[i]);
        end

        // Both requests rise together: video first, CPU one slot later.
        @(negedge clk);
        a10 = tv_a[2];
        bus.vid_req = 1; bus.vid_addr = a10[AW-1:0];
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a10[AW-1:0];
        vl = 0; cl = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.vid_valid && vl == 0) begin vl = k; bus.vid_req = 0; end
            if (bus.cpu_ack && cl == 0) begin cl = k; bus.cpu_req = 0; end
        end
        check("simul_vid_lat", vl, 3);
        check("simul_cpu_lat", cl, 4);
        check("simul_vid_data", bus.vid_dout, 8'hA5);

        // Video held continuously with the CPU also requesting.
        @(negedge clk);
        bus.vid_req = 1; bus.vid_addr = '0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = AW'(1);
        nv = 0; nc = 0; cl = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.vid_valid) nv++;
            if (bus.cpu_ack) begin nc++; if (cl == 0) cl = k; end
            bus.vid_addr = bus.vid_addr + AW'(1);
        end
        bus.vid_req = 0; bus.cpu_req = 0;
        check("starve_first_cpu", cl, 4);
        check("starve_vid_count", nv, 4);
        check("starve_cpu_count", nc, 3);
        repeat (6) @(negedge clk);

        // Reset one cycle after a CPU read is issued.
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a10[AW-1:0];
        @(posedge clk);
        @(posedge clk); #2 reset_n = 0; bus.cpu_req = 0;
        #1;
        check("mid_rst_ack", bus.cpu_ack, 0);
        check("mid_rst_cpu_dout", bus.cpu_dout, 0);
        check("mid_rst_vid_dout", bus.vid_dout, 0);
        check("mid_rst_addr", bus.ram_address, 0);
        check("mid_rst_data", bus.ram_data, 0);
        check("mid_rst_wren", bus.ram_wren, 0);
        check("mid_rst_busy", clear_busy, CLR);
        @(negedge clk); reset_n = 1;
        nc = 0;
        repeat (2**AW + 6) begin
            @(negedge clk);
            if (bus.cpu_ack) nc++;
        end
        check("mid_rst_no_ack", nc, 0);
        cpu_op(1, AW'(3), 8'hC3, lat, q);
        cpu_op(0, AW'(3), 8'h00, lat, q);
        check("post_rst_rd", q, 8'hC3);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
